zbt_access_arbiter: RTL and testbench
=====================================

Name: zbt_access_arbiter

Overview:
Shares the single-port pipelined ZBT SRAM between two requesters.
- Write requester: the optical receiver, which stores CRC-good 36-bit words at 19-bit packet addresses.
- Read requester: the playback/recorder path.
Writes are buffered in a small FIFO so the receiver never stalls on a read burst. The block issues at most one ZBT operation per cycle, enforces read-after-write ordering on matching addresses, and returns read data with a fixed latency.

Parameters:
ADDR_W, 19, ZBT word address width
DATA_W, 36, ZBT data width
WFIFO_DEPTH, 4, write FIFO entries; power of two, at least 2
RD_LAT, 2, ZBT read latency in cycles from address to data
STARVE_MAX, 8, consecutive read grants allowed while the write FIFO is non-empty

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_req  in  1  receiver write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ready  out  1  FIFO not full; a write is accepted when wr_req && wr_ready
rd_req  in  1  playback read request
rd_addr  in  ADDR_W  read address
rd_ready  out  1  read granted this cycle (combinational)
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data valid, one-cycle pulse
zbt_addr  out  ADDR_W  registered ZBT address
zbt_we  out  1  registered ZBT write enable
zbt_wdata  out  DATA_W  ZBT write data, aligned to the ZBT write pipeline
zbt_rdata  in  DATA_W  ZBT read data
wfifo_count  out  log2(WFIFO_DEPTH)+1  current write FIFO occupancy

Behaviour:
- Reset (synchronous): all outputs are 0; FIFO is emptied; starvation counter is 0; read-return and write-data pipelines are flushed. In-flight reads are dropped and produce no rd_valid. Writes still in the FIFO are discarded.
- wr_ready = (wfifo_count != WFIFO_DEPTH), computed from the registered count.
  - A push while full is impossible.
  - A push and a pop in the same cycle leave the count unchanged.
- Grant is decided each cycle, combinationally, in this priority order:
  1. FIFO full: grant write; rd_ready = 0.
  2. Hazard: rd_req is set and rd_addr equals the address of any valid FIFO entry. Grant write (drain); rd_ready = 0.
  3. starve_cnt == STARVE_MAX and FIFO non-empty: grant write.
  4. rd_req is set: grant read; rd_ready = 1.
  5. FIFO non-empty: grant write.
  6. Otherwise idle.
- Starvation counter:
  - Increments on each read grant while the FIFO is non-empty, saturating at STARVE_MAX.
  - Clears on any write grant, or when the FIFO is empty.
- Write grant: pop the FIFO head.
  - Next cycle: zbt_addr = head address, zbt_we = 1.
  - zbt_wdata = head data, delayed RD_LAT cycles after zbt_addr, to match the ZBT late-write pipeline.
- Read grant:
  - Next cycle: zbt_addr = rd_addr, zbt_we = 0.
  - rd_valid pulses RD_LAT cycles after that, with rd_data = zbt_rdata sampled the same cycle.
  - Total latency from a rd_ready cycle to rd_valid: RD_LAT+1 cycles (3 at default).
- Idle cycle: zbt_we = 0 and zbt_addr holds its last value.
- A write accepted in the same cycle as a matching read request is included in the hazard check only from the next cycle. The requester must not issue a read to an address it is writing in the same cycle.
- Back-to-back reads at full rate: one per cycle. rd_valid pulses are contiguous and in order.
- Address match compares all ADDR_W bits against valid entries only. Stale slots never match.

Optional Feature:
Macro: ZBT_ARB_STATS_EN.
- When defined, adds outputs stat_writes, stat_reads and stat_hazards, each 16 bits and saturating.
  - stat_writes counts write grants.
  - stat_reads counts read grants.
  - stat_hazards counts cycles in which a read was blocked by a hazard.
  - All three clear on reset.
- When undefined, these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset check: hold reset 3 cycles with wr_req=1 and rd_req=1 → wr_ready=1 after reset, all other outputs 0, wfifo_count=0, no rd_valid.
- Single write then read:
  - Write addr 0x00010, data 0x123456789 → zbt_we=1 at 0x00010 one cycle after grant; zbt_wdata=0x123456789 two cycles later.
  - Read 0x00010 → rd_valid 3 cycles after rd_ready, with rd_data equal to the zbt_rdata model value.
- Hazard: push writes to 0x00020 and 0x00021, then immediately read 0x00021 → rd_ready=0 until both writes have issued; the read is then granted; returned data is the written value.
- Starvation: FIFO holds 1 entry and rd_req is held continuously → exactly 8 read grants, then 1 write grant, then reads resume.
- FIFO full: 4 writes while reads hog the port → wr_ready=0 with count=4; a 5th wr_req is not accepted; a write grant is forced next cycle.
- Mid-operation reset: assert reset one cycle after a read grant → no rd_valid follows; FIFO empty; stat counters (with ZBT_ARB_STATS_EN) read 0.

Source files
------------

// File: rtl/zbt_access_arbiter.sv
// zbt_access_arbiter
// Shares one pipelined ZBT SRAM port between the optical receiver (writes,
// buffered in a small FIFO) and the playback/recorder path (reads).
// One ZBT operation per cycle. Read-after-write ordering is kept by
// draining the FIFO whenever a read address matches a queued write.
// A bounded starvation counter guarantees queued writes make progress.
// Optional macro ZBT_ARB_STATS_EN adds saturating 16-bit grant/hazard counters.
module zbt_access_arbiter #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 36,
    parameter int WFIFO_DEPTH = 4,
    parameter int RD_LAT      = 2,
    parameter int STARVE_MAX  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_req,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_ready,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic [ADDR_W-1:0]             zbt_addr,
    output logic                          zbt_we,
    output logic [DATA_W-1:0]             zbt_wdata,
    input  logic [DATA_W-1:0]             zbt_rdata,
    output logic [$clog2(WFIFO_DEPTH):0]  wfifo_count
`ifdef ZBT_ARB_STATS_EN
    ,
    output logic [15:0]                   stat_writes,
    output logic [15:0]                   stat_reads,
    output logic [15:0]                   stat_hazards
`endif
);

    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0]      fifo_addr [WFIFO_DEPTH];
    logic [DATA_W-1:0]      fifo_data [WFIFO_DEPTH];
    logic [WFIFO_DEPTH-1:0] fifo_vld;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop;
    logic                   addr_hit, hazard;
    logic                   grant_wr, grant_rd;
    // Remaining read grants allowed before a queued write is forced through.
    logic [SC_W-1:0]        starve_left;
    logic [RD_LAT:0]        rd_pipe;
    logic [DATA_W-1:0]      wd_pipe [RD_LAT+1];

    assign fifo_full  = (wfifo_count == CNT_W'(WFIFO_DEPTH));
    assign fifo_empty = (wfifo_count == '0);
    assign wr_ready   = !fifo_full;
    assign push       = wr_req && wr_ready;
    assign pop        = grant_wr;
    assign rd_ready   = grant_rd;
    assign rd_valid   = rd_pipe[RD_LAT];
    assign rd_data    = rd_valid ? zbt_rdata : '0;
    assign zbt_wdata  = wd_pipe[RD_LAT];

    // Compare the read address against every occupied FIFO slot.
    always_comb begin
        addr_hit = 1'b0;
        for (int i = 0; i < WFIFO_DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_addr[i] == rd_addr)) begin
                addr_hit = 1'b1;
            end
        end
        hazard = rd_req && addr_hit;
    end

    // Per-cycle grant: full, hazard, starvation, read, pending write, idle.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (fifo_full) begin
            grant_wr = 1'b1;
        end else if (hazard) begin
            grant_wr = 1'b1;
        end else if ((starve_left == '0) && !fifo_empty) begin
            grant_wr = 1'b1;
        end else if (rd_req) begin
            grant_rd = 1'b1;
        end else if (!fifo_empty) begin
            grant_wr = 1'b1;
        end
    end

    // FIFO storage; contents are only meaningful where fifo_vld is set.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and per-slot valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wfifo_count <= '0;
            fifo_vld    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   wfifo_count <= wfifo_count + CNT_W'(1);
                2'b01:   wfifo_count <= wfifo_count - CNT_W'(1);
                default: wfifo_count <= wfifo_count;
            endcase
            // Push and pop never target the same slot: that needs empty or full.
            if (pop)  fifo_vld[rd_ptr] <= 1'b0;
            if (push) fifo_vld[wr_ptr] <= 1'b1;
        end
    end

    // Starvation down-counter; reloads on a write grant or when nothing is queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_left <= SC_W'(STARVE_MAX);
        end else if (grant_wr || fifo_empty) begin
            starve_left <= SC_W'(STARVE_MAX);
        end else if (grant_rd && (starve_left != '0)) begin
            starve_left <= starve_left - SC_W'(1);
        end
    end

    // Registered ZBT command; the address holds on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            zbt_addr <= '0;
            zbt_we   <= 1'b0;
        end else begin
            zbt_we <= grant_wr;
            if (grant_wr) begin
                zbt_addr <= fifo_addr[rd_ptr];
            end else if (grant_rd) begin
                zbt_addr <= rd_addr;
            end
        end
    end

    // Read-return tracker and late-write data pipe, both RD_LAT behind zbt_addr.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pipe <= '0;
            for (int i = 0; i <= RD_LAT; i++) wd_pipe[i] <= '0;
        end else begin
            rd_pipe    <= {rd_pipe[RD_LAT-1:0], grant_rd};
            wd_pipe[0] <= grant_wr ? fifo_data[rd_ptr] : '0;
            for (int i = 1; i <= RD_LAT; i++) wd_pipe[i] <= wd_pipe[i-1];
        end
    end

`ifdef ZBT_ARB_STATS_EN
    // Saturating activity counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_writes  <= '0;
            stat_reads   <= '0;
            stat_hazards <= '0;
        end else begin
            if (grant_wr && (stat_writes != 16'hFFFF))  stat_writes  <= stat_writes + 16'd1;
            if (grant_rd && (stat_reads != 16'hFFFF))   stat_reads   <= stat_reads + 16'd1;
            if (hazard && (stat_hazards != 16'hFFFF))   stat_hazards <= stat_hazards + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_zbt_access_arbiter.sv
// Directed testbench for zbt_access_arbiter with a small ZBT SRAM model
// (RD_LAT=2 read latency, late-write data two cycles after the address).
module tb_zbt_access_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_req = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [35:0] wr_data = '0;
    logic        wr_ready;
    logic        rd_req = 1'b0;
    logic [18:0] rd_addr = '0;
    logic        rd_ready;
    logic [35:0] rd_data;
    logic        rd_valid;
    logic [18:0] zbt_addr;
    logic        zbt_we;
    logic [35:0] zbt_wdata;
    logic [35:0] zbt_rdata;
    logic [2:0]  wfifo_count;
`ifdef ZBT_ARB_STATS_EN
    logic [15:0] stat_writes, stat_reads, stat_hazards;
`endif

    int n_checks = 0;
    int n_fail = 0;

    zbt_access_arbiter dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .zbt_addr(zbt_addr), .zbt_we(zbt_we), .zbt_wdata(zbt_wdata),
        .zbt_rdata(zbt_rdata), .wfifo_count(wfifo_count)
`ifdef ZBT_ARB_STATS_EN
        , .stat_writes(stat_writes), .stat_reads(stat_reads), .stat_hazards(stat_hazards)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] init_word(input int a);
        return 36'hC00000000 | 36'(a);
    endfunction

    // ZBT model: command pipe of depth 2, write commits when its data arrives.
    logic [35:0] mem [0:255];
    logic [18:0] a1 = '0, a2 = '0;
    logic        w1 = 1'b0, w2 = 1'b0;

    initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);

    always @(posedge clk) begin
        a1 <= zbt_addr; w1 <= zbt_we;
        a2 <= a1;       w2 <= w1;
        if (w2) mem[a2[7:0]] <= zbt_wdata;
    end
    assign zbt_rdata = w2 ? 36'h0 : mem[a2[7:0]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_addr = 19'h5; rd_addr = 19'h6;
        repeat (3) tick();
        reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        #1;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %0b want 1", wr_ready); end
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ready got %0b want 0", rd_ready); end
        n_checks++; if (wfifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", wfifo_count); end
        n_checks++; if ({zbt_we, zbt_addr, zbt_wdata} !== '0) begin n_fail++; $display("FAIL reset_zbt got we=%0b addr=%h wdata=%h want 0", zbt_we, zbt_addr, zbt_wdata); end
        n_checks++; if ({rd_valid, rd_data} !== '0) begin n_fail++; $display("FAIL reset_rd got valid=%0b data=%h want 0", rd_valid, rd_data); end
        tick();
    endtask

    task automatic test_write_read;
        wr_req = 1'b1; wr_addr = 19'h10; wr_data = 36'h123456789;
        #1;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_accept got %0b want 1", wr_ready); end
        tick();
        wr_req = 1'b0;
        #1;
        n_checks++; if (wfifo_count !== 3'd1) begin n_fail++; $display("FAIL wr_count got %0d want 1", wfifo_count); end
        tick(); #1;
        n_checks++; if (zbt_we !== 1'b1 || zbt_addr !== 19'h10) begin n_fail++; $display("FAIL wr_issue got we=%0b addr=%h want 1/00010", zbt_we, zbt_addr); end
        tick(); #1;
        n_checks++; if (zbt_we !== 1'b0 || zbt_addr !== 19'h10) begin n_fail++; $display("FAIL idle_hold got we=%0b addr=%h want 0/00010", zbt_we, zbt_addr); end
        tick(); #1;
        n_checks++; if (zbt_wdata !== 36'h123456789) begin n_fail++; $display("FAIL wr_wdata got %h want 123456789", zbt_wdata); end
        tick();
        rd_req = 1'b1; rd_addr = 19'h10;
        #1;
        n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_grant got %0b want 1", rd_ready); end
        tick();
        rd_req = 1'b0;
        #1;
        n_checks++; if (zbt_we !== 1'b0 || zbt_addr !== 19'h10 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_issue got we=%0b addr=%h valid=%0b want 0/00010/0", zbt_we, zbt_addr, rd_valid); end
        tick(); #1;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early got %0b want 0", rd_valid); end
        tick(); #1;
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 36'h123456789) begin n_fail++; $display("FAIL rd_return got valid=%0b data=%h want 1/123456789", rd_valid, rd_data); end
        tick(); #1;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse got %0b want 0", rd_valid); end
        tick();
    endtask

    task automatic test_hazard;
        wr_req = 1'b1; wr_addr = 19'h20; wr_data = 36'hABCDE0020; rd_req = 1'b1; rd_addr = 19'h99;
        #1;
        n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL hz_h0_rd got %0b want 1", rd_ready); end
        tick();
        wr_addr = 19'h21; wr_data = 36'h135790021;
        #1;
        n_checks++; if (rd_ready !== 1'b1 || wfifo_count !== 3'd1) begin n_fail++; $display("FAIL hz_h1 got rd=%0b cnt=%0d want 1/1", rd_ready, wfifo_count); end
        tick();
        wr_req = 1'b0; rd_addr = 19'h21;
        #1;
        n_checks++; if (rd_ready !== 1'b0 || wfifo_count !== 3'd2) begin n_fail++; $display("FAIL hz_block1 got rd=%0b cnt=%0d want 0/2", rd_ready, wfifo_count); end
        tick(); #1;
        n_checks++; if (rd_ready !== 1'b0 || wfifo_count !== 3'd1) begin n_fail++; $display("FAIL hz_block2 got rd=%0b cnt=%0d want 0/1", rd_ready, wfifo_count); end
        n_checks++; if (zbt_we !== 1'b1 || zbt_addr !== 19'h20) begin n_fail++; $display("FAIL hz_drain1 got we=%0b addr=%h want 1/00020", zbt_we, zbt_addr); end
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== init_word(32'h99)) begin n_fail++; $display("FAIL hz_rd99 got valid=%0b data=%h want 1/%h", rd_valid, rd_data, init_word(32'h99)); end
        tick(); #1;
        n_checks++; if (rd_ready !== 1'b1 || wfifo_count !== 3'd0) begin n_fail++; $display("FAIL hz_release got rd=%0b cnt=%0d want 1/0", rd_ready, wfifo_count); end
        n_checks++; if (zbt_we !== 1'b1 || zbt_addr !== 19'h21) begin n_fail++; $display("FAIL hz_drain2 got we=%0b addr=%h want 1/00021", zbt_we, zbt_addr); end
        tick();
        rd_req = 1'b0;
        #1;
        n_checks++; if (zbt_we !== 1'b0 || zbt_addr !== 19'h21 || zbt_wdata !== 36'hABCDE0020) begin n_fail++; $display("FAIL hz_h5 got we=%0b addr=%h wdata=%h want 0/00021/abcde0020", zbt_we, zbt_addr, zbt_wdata); end
        tick(); #1;
        n_checks++; if (zbt_wdata !== 36'h135790021 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL hz_h6 got wdata=%h valid=%0b want 135790021/0", zbt_wdata, rd_valid); end
        tick(); #1;
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 36'h135790021) begin n_fail++; $display("FAIL hz_raw got valid=%0b data=%h want 1/135790021", rd_valid, rd_data); end
`ifdef ZBT_ARB_STATS_EN
        n_checks++; if (stat_hazards !== 16'd2) begin n_fail++; $display("FAIL hz_stat got %0d want 2", stat_hazards); end
`endif
        tick();
    endtask

    task automatic test_starvation;
        int n;
        bit stalled;
        n = 0; stalled = 1'b0;
        wr_req = 1'b1; wr_addr = 19'h30; wr_data = 36'hF0F0F0030; rd_req = 1'b1; rd_addr = 19'h40;
        #1;
        n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL st_first got %0b want 1", rd_ready); end
        tick();
        wr_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (rd_ready !== 1'b1) begin stalled = 1'b1; break; end
            n++;
            tick();
        end
        n_checks++; if (!stalled) begin n_fail++; $display("FAIL st_timeout got no write grant in 16 cycles want stall"); end
        n_checks++; if (n != 8 || wfifo_count !== 3'd1) begin n_fail++; $display("FAIL st_count got %0d grants cnt=%0d want 8/1", n, wfifo_count); end
        tick(); #1;
        n_checks++; if (rd_ready !== 1'b1 || wfifo_count !== 3'd0) begin n_fail++; $display("FAIL st_resume got rd=%0b cnt=%0d want 1/0", rd_ready, wfifo_count); end
        n_checks++; if (zbt_we !== 1'b1 || zbt_addr !== 19'h30) begin n_fail++; $display("FAIL st_write got we=%0b addr=%h want 1/00030", zbt_we, zbt_addr); end
        tick();
        rd_req = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_fifo_full;
        bit drained;
        drained = 1'b0;
        rd_req = 1'b1; rd_addr = 19'h50;
        for (int k = 0; k < 4; k++) begin
            wr_req = 1'b1; wr_addr = 19'(32'h60 + k); wr_data = 36'h600000000 | 36'(32'h60 + k);
            #1;
            n_checks++; if (rd_ready !== 1'b1 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL ff_fill%0d got rd=%0b wr=%0b want 1/1", k, rd_ready, wr_ready); end
            tick();
        end
        wr_addr = 19'h64; wr_data = 36'h600000064;
        #1;
        n_checks++; if (wr_ready !== 1'b0 || wfifo_count !== 3'd4 || rd_ready !== 1'b0) begin n_fail++; $display("FAIL ff_full got wr=%0b cnt=%0d rd=%0b want 0/4/0", wr_ready, wfifo_count, rd_ready); end
        tick();
        wr_req = 1'b0;
        #1;
        n_checks++; if (wfifo_count !== 3'd3 || zbt_we !== 1'b1 || zbt_addr !== 19'h60) begin n_fail++; $display("FAIL ff_forced got cnt=%0d we=%0b addr=%h want 3/1/00060", wfifo_count, zbt_we, zbt_addr); end
        tick();
        rd_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (wfifo_count === 3'd0) begin drained = 1'b1; break; end
            tick();
        end
        n_checks++; if (!drained) begin n_fail++; $display("FAIL ff_drain got cnt=%0d after 20 cycles want 0", wfifo_count); end
        repeat (5) tick();
        n_checks++; if (mem[8'h63] !== 36'h600000063) begin n_fail++; $display("FAIL ff_last got %h want 600000063", mem[8'h63]); end
        n_checks++; if (mem[8'h64] !== init_word(32'h64)) begin n_fail++; $display("FAIL ff_reject got %h want %h", mem[8'h64], init_word(32'h64)); end
    endtask

    task automatic test_back_to_back;
        logic [35:0] exp_d;
        for (int k = 0; k < 8; k++) begin
            rd_req = (k < 4);
            rd_addr = 19'(32'h70 + k);
            #1;
            if (k >= 3 && k < 7) begin
                exp_d = init_word(32'h70 + k - 3);
                n_checks++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin n_fail++; $display("FAIL b2b_%0d got valid=%0b data=%h want 1/%h", k, rd_valid, rd_data, exp_d); end
            end else begin
                n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle%0d got %0b want 0", k, rd_valid); end
            end
            tick();
        end
        rd_req = 1'b0;
    endtask

    task automatic test_mid_reset;
        bit seen;
        seen = 1'b0;
        wr_req = 1'b1; wr_addr = 19'h80; wr_data = 36'h800000080; rd_req = 1'b1; rd_addr = 19'h10;
        #1;
        n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL mr_grant got %0b want 1", rd_ready); end
        tick();
        wr_req = 1'b0; rd_req = 1'b0; reset = 1'b1;
        #1;
        n_checks++; if (wfifo_count !== 3'd1) begin n_fail++; $display("FAIL mr_queued got %0d want 1", wfifo_count); end
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (wfifo_count !== 3'd0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL mr_fifo got cnt=%0d wr=%0b want 0/1", wfifo_count, wr_ready); end
        n_checks++; if (zbt_we !== 1'b0 || zbt_addr !== 19'h0) begin n_fail++; $display("FAIL mr_zbt got we=%0b addr=%h want 0/00000", zbt_we, zbt_addr); end
`ifdef ZBT_ARB_STATS_EN
        n_checks++; if ({stat_writes, stat_reads, stat_hazards} !== '0) begin n_fail++; $display("FAIL mr_stats got %0d/%0d/%0d want 0/0/0", stat_writes, stat_reads, stat_hazards); end
`endif
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rd_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL mr_dropped got rd_valid=1 want none"); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hazard();
        test_starvation();
        test_fifo_full();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
